// File: rtl/spi_slave_if.sv
// SPI mode-0 responder: oversamples SCLK/CS_N/MOSI on clk_in, hands received words to fabric
// and shifts fabric words onto MISO. Build with SPI_SLAVE_UNDERRUN_EN to add the tx_underrun pulse.
module spi_slave_if #(
   parameter int                WIDTH       = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0]  DEFAULT_TX  = 8'hFF
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready
`ifdef SPI_SLAVE_UNDERRUN_EN
   ,
   output logic             tx_underrun
`endif
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;
   logic [CW-1:0]          r_bit_cnt;
   logic [WIDTH-2:0]       r_rx_shift;
   logic [WIDTH-2:0]       r_tx_shift;
   logic                   r_rx_pend;

   logic                   w_sclk_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_sclk_rise;
   logic                   w_sclk_fall;
   logic                   w_cs_fall;
   logic                   w_cs_rise;
   logic [WIDTH-1:0]       w_load_word;
   logic [WIDTH-1:0]       w_rx_word;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_fall   = ~w_cs_s & r_cs_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;
   assign w_load_word = tx_valid ? tx_data : DEFAULT_TX;
   assign w_rx_word   = {r_rx_shift, w_mosi_s};

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_sclk_d    <= w_sclk_s;
         r_cs_d      <= w_cs_s;
      end
   end

   // rx_data is written one cycle ahead of the rx_valid pulse so it is settled when the pulse is seen.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_rx_shift <= '0;
         r_tx_shift <= '0;
         r_rx_pend  <= 1'b0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         tx_ready   <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
         tx_underrun <= 1'b0;
`endif
      end else begin
         rx_valid  <= r_rx_pend;
         r_rx_pend <= 1'b0;
         tx_ready  <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
         tx_underrun <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               miso_oe   <= 1'b0;
               r_bit_cnt <= '0;
               if (w_cs_fall) begin
                  r_state    <= S_ACTIVE;
                  miso_oe    <= 1'b1;
                  r_tx_shift <= w_load_word[WIDTH-2:0];
                  miso       <= w_load_word[WIDTH-1];
                  tx_ready   <= tx_valid;
`ifdef SPI_SLAVE_UNDERRUN_EN
                  tx_underrun <= ~tx_valid;
`endif
               end
            end
            S_ACTIVE: begin
               miso_oe <= 1'b1;
               if (w_cs_rise) begin
                  r_state    <= S_IDLE;
                  miso_oe    <= 1'b0;
                  miso       <= 1'b0;
                  r_bit_cnt  <= '0;
                  r_rx_shift <= '0;
                  r_tx_shift <= '0;
               end else if (w_sclk_rise) begin
                  r_rx_shift <= w_rx_word[WIDTH-2:0];
                  if (r_bit_cnt == LAST) begin
                     rx_data   <= w_rx_word;
                     r_rx_pend <= 1'b1;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CW'(1);
                  end
               end else if (w_sclk_fall) begin
                  // bit_cnt==0 after a fall means a word just completed: reload for back-to-back words.
                  if (r_bit_cnt != '0) begin
                     miso       <= r_tx_shift[WIDTH-2];
                     r_tx_shift <= {r_tx_shift[WIDTH-3:0], 1'b0};
                  end else begin
                     r_tx_shift <= w_load_word[WIDTH-2:0];
                     miso       <= w_load_word[WIDTH-1];
                     tx_ready   <= tx_valid;
`ifdef SPI_SLAVE_UNDERRUN_EN
                     tx_underrun <= ~tx_valid;
`endif
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: table-driven single-word transfers, randomized multi-word frames
// against a queue-based model, and hand-written abort/reset/idle sequences.
module tb_spi_slave_if;

   localparam int SYNC_STAGES = 2;
   localparam int H = 4; // SCLK half period in clk_in cycles (SCLK = clk_in/8)

   logic       clk_in = 1'b0;
   logic       rst, sclk, cs_n, mosi;
   logic       miso, miso_oe, rx_valid, tx_ready, tx_valid;
   logic [7:0] rx_data, tx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
   logic       tx_underrun;
`endif

   always #5 clk_in = ~clk_in;

   spi_slave_if #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .DEFAULT_TX(8'hFF)) dut (
      .clk_in(clk_in), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`ifdef SPI_SLAVE_UNDERRUN_EN
      , .tx_underrun(tx_underrun)
`endif
   );

   int n_chk = 0, n_err = 0;
   int cyc = 0, rise_cyc = 0, last_lat = -1;
   int n_rxv = 0, n_txr = 0, n_und = 0, width_err = 0, oe_bad = 0;
   logic prev_rxv = 1'b0;
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [7:0] m_out[4];
   logic [7:0] m_in[4];

   typedef struct {
      logic [7:0] mo;
      logic [7:0] td;
      bit         tv;
      logic [7:0] exp_rx;
      logic [7:0] exp_mi;
      int         exp_rdy;
   } vec_t;
   vec_t tbl[5];

   always @(posedge clk_in) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // Fabric model and output monitor, all on the negative edge.
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(negedge clk_in);
         if (rx_valid) begin
            n_rxv++;
            rxq.push_back(rx_data);
            if (prev_rxv) width_err++;
            else last_lat = cyc - rise_cyc;
         end
         prev_rxv = rx_valid;
         if (tx_ready) begin
            n_txr++;
            if (txq.size() > 0) void'(txq.pop_front());
         end
`ifdef SPI_SLAVE_UNDERRUN_EN
         if (tx_underrun) n_und++;
`endif
         tx_valid = (txq.size() > 0);
         tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
      end
   end

   // Master side: MOSI set on the falling edge, MISO sampled at the rising edge.
   task automatic do_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7-i];
         wait_cyc(H);
         got[7-i] = miso;
         if (miso_oe !== 1'b1) oe_bad++;
         sclk = 1'b1;
         rise_cyc = cyc;
         wait_cyc(H);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input int nw);
      logic [7:0] g;
      cs_n = 1'b0;
      wait_cyc(H);
      for (int w = 0; w < nw; w++) begin
         do_bits(m_out[w], 8, g);
         m_in[w] = g;
      end
      wait_cyc(H);
      cs_n = 1'b1;
      wait_cyc(12);
   endtask

   initial begin
      int b_rx, b_rdy, b_und, nw, k;
      logic [7:0] txw[4];
      logic [7:0] g;

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      wait_cyc(4);
      chk("reset_miso", miso, 0);
      chk("reset_miso_oe", miso_oe, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_tx_ready", tx_ready, 0);
      rst = 1'b0;
      wait_cyc(6);

      tbl[0] = '{8'hA5, 8'h3C, 1, 8'hA5, 8'h3C, 1};
      tbl[1] = '{8'h00, 8'h12, 0, 8'h00, 8'hFF, 0};
      tbl[2] = '{8'hC3, 8'h5A, 1, 8'hC3, 8'h5A, 1};
      tbl[3] = '{8'hFF, 8'h00, 1, 8'hFF, 8'h00, 1};
      tbl[4] = '{8'h7E, 8'h81, 1, 8'h7E, 8'h81, 1};

      for (int v = 0; v < 5; v++) begin
         rxq.delete();
         b_rx = n_rxv; b_rdy = n_txr; b_und = n_und; oe_bad = 0;
         if (tbl[v].tv) txq.push_back(tbl[v].td);
         wait_cyc(3);
         m_out[0] = tbl[v].mo;
         frame(1);
         chk("vec_rx_count", n_rxv - b_rx, 1);
         chk("vec_rx_data", (rxq.size() > 0) ? int'(rxq[0]) : -1, tbl[v].exp_rx);
         chk("vec_miso_word", m_in[0], tbl[v].exp_mi);
         chk("vec_tx_ready_count", n_txr - b_rdy, tbl[v].exp_rdy);
         chk("vec_miso_oe_active", oe_bad, 0);
         chk("vec_miso_oe_idle", miso_oe, 0);
         if (v == 0) chk("rx_latency", last_lat, SYNC_STAGES + 2);
`ifdef SPI_SLAVE_UNDERRUN_EN
         if (!tbl[v].tv) chk("underrun_seen", (n_und - b_und) > 0 ? 1 : 0, 1);
`endif
      end

      // Back-to-back words in one CS window.
      rxq.delete();
      b_rx = n_rxv; b_rdy = n_txr;
      txq.push_back(8'h55); txq.push_back(8'hAA);
      wait_cyc(3);
      m_out[0] = 8'h01; m_out[1] = 8'h80;
      frame(2);
      chk("b2b_rx_count", n_rxv - b_rx, 2);
      chk("b2b_rx0", (rxq.size() > 0) ? int'(rxq[0]) : -1, 8'h01);
      chk("b2b_rx1", (rxq.size() > 1) ? int'(rxq[1]) : -1, 8'h80);
      chk("b2b_miso0", m_in[0], 8'h55);
      chk("b2b_miso1", m_in[1], 8'hAA);
      chk("b2b_tx_ready_count", n_txr - b_rdy, 2);

      // Randomized frames: fabric supplies k of nw words, remainder must be DEFAULT_TX.
      for (int r = 0; r < 20; r++) begin
         rxq.delete();
         b_rx = n_rxv; b_rdy = n_txr;
         nw = $urandom_range(1, 3);
         k  = $urandom_range(0, nw);
         for (int w = 0; w < nw; w++) begin
            m_out[w] = 8'($urandom);
            txw[w]   = 8'($urandom);
            if (w < k) txq.push_back(txw[w]);
         end
         wait_cyc(3);
         frame(nw);
         chk("rnd_rx_count", n_rxv - b_rx, nw);
         chk("rnd_tx_ready_count", n_txr - b_rdy, k);
         for (int w = 0; w < nw; w++) begin
            chk("rnd_rx_word", (rxq.size() > w) ? int'(rxq[w]) : -1, m_out[w]);
            chk("rnd_miso_word", m_in[w], (w < k) ? txw[w] : 8'hFF);
         end
      end

      // CS_N raised mid-word, then a clean word.
      rxq.delete();
      b_rx = n_rxv;
      cs_n = 1'b0;
      wait_cyc(H);
      do_bits(8'hF0, 5, g);
      wait_cyc(H);
      cs_n = 1'b1;
      wait_cyc(10);
      chk("abort_no_rx_valid", n_rxv - b_rx, 0);
      chk("abort_miso_oe", miso_oe, 0);
      m_out[0] = 8'h0F;
      frame(1);
      chk("abort_next_rx_count", n_rxv - b_rx, 1);
      chk("abort_next_rx_data", (rxq.size() > 0) ? int'(rxq[0]) : -1, 8'h0F);

      // Reset pulsed after 3 bits.
      rxq.delete();
      cs_n = 1'b0;
      wait_cyc(H);
      do_bits(8'hE7, 3, g);
      chk("pre_reset_miso_oe", miso_oe, 1);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      chk("mid_reset_miso", miso, 0);
      chk("mid_reset_miso_oe", miso_oe, 0);
      chk("mid_reset_rx_data", rx_data, 0);
      chk("mid_reset_rx_valid", rx_valid, 0);
      chk("mid_reset_tx_ready", tx_ready, 0);
      cs_n = 1'b1;
      wait_cyc(10);
      b_rx = n_rxv;
      rxq.delete();
      m_out[0] = 8'hC3;
      frame(1);
      chk("post_reset_rx_count", n_rxv - b_rx, 1);
      chk("post_reset_rx_data", (rxq.size() > 0) ? int'(rxq[0]) : -1, 8'hC3);

      // SCLK activity with CS_N high must be ignored.
      txq.push_back(8'h77);
      wait_cyc(3);
      b_rx = n_rxv; b_rdy = n_txr;
      oe_bad = 0;
      for (int i = 0; i < 8; i++) begin
         sclk = 1'b1;
         wait_cyc(H);
         if (miso_oe !== 1'b0) oe_bad++;
         sclk = 1'b0;
         wait_cyc(H);
      end
      wait_cyc(6);
      chk("idle_no_rx_valid", n_rxv - b_rx, 0);
      chk("idle_no_tx_ready", n_txr - b_rdy, 0);
      chk("idle_miso_oe_low", oe_bad, 0);
      txq.delete();
      wait_cyc(3);

      chk("rx_valid_width", width_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected completion");
      $fatal(1);
   end

endmodule
